d_flip_flop_rst: RTL and testbench



---
 rtl/d_flip_flop_bit.sv | 33 +++
 rtl/d_flip_flop_rst.sv | 34 +++
 tb/tb_d_flip_flop_rst.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/d_flip_flop_bit.sv
// rtl/d_flip_flop_bit.sv - single-bit D-type storage cell with synchronous active-high reset
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous, active-high; priority over d
//   d         data captured on the rising edge
//   reset_val value loaded when reset is sampled high
//   q         registered data
module d_flip_flop_bit (
    input  logic clock,
    input  logic reset,
    input  logic d,
    input  logic reset_val,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = d;
        if (reset) begin
            q_d = reset_val;
        end
    end

    always_ff @(posedge clock) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/d_flip_flop_rst.sv
// rtl/d_flip_flop_rst.sv - WIDTH-bit D-type register with synchronous reset and complementary output
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; loads RESET_VAL
//   d      [WIDTH-1:0] data captured on the rising edge
//   q      [WIDTH-1:0] registered data
//   q_bar  [WIDTH-1:0] bitwise complement of q
module d_flip_flop_rst #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_flip_flop_bit u_bit (
            .clock     (clock),
            .reset     (reset),
            .d         (d[i]),
            .reset_val (RESET_VAL[i]),
            .q         (q[i])
        );
    end

    // Derived from the stored bits rather than kept in its own flop, so it
    // can never disagree with q.
    assign q_bar = ~q;

endmodule

// File: tb/tb_d_flip_flop_rst.sv
// tb/tb_d_flip_flop_rst.sv - scoreboard bench for d_flip_flop_rst (WIDTH=1 and WIDTH=4 instances)
module tb_d_flip_flop_rst;

    localparam logic [3:0] RV4 = 4'b1010;

    logic       clock = 1'b0;
    logic       r1;
    logic       d1;
    logic       q1;
    logic       qb1;
    logic       r4;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [3:0] qb4;

    int errors = 0;
    int checks = 0;

    logic       exp1_q[$];
    logic [3:0] exp4_q[$];
    logic       last1;
    logic [3:0] last4;

    always #10 clock = ~clock;

    d_flip_flop_rst u_dut1 (
        .clock (clock),
        .reset (r1),
        .d     (d1),
        .q     (q1),
        .q_bar (qb1)
    );

    d_flip_flop_rst #(
        .WIDTH     (4),
        .RESET_VAL (RV4)
    ) u_dut4 (
        .clock (clock),
        .reset (r4),
        .d     (d4),
        .q     (q4),
        .q_bar (qb4)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b required %b", name, $time, act, req);
        end
    endtask

    // Reference: whatever is presented before an edge determines q after it.
    task automatic push_expect();
        logic       e1;
        logic [3:0] e4;
        e1 = r1 ? 1'b0 : d1;
        e4 = r4 ? RV4 : d4;
        exp1_q.push_back(e1);
        exp4_q.push_back(e4);
        last1 = e1;
        last4 = e4;
    endtask

    task automatic step(input logic nr1, input logic nd1, input logic nr4, input logic [3:0] nd4);
        @(posedge clock);
        #2;
        r1 = nr1; d1 = nd1; r4 = nr4; d4 = nd4;
        push_expect();
    endtask

    // Change reset and d mid-cycle and confirm nothing moves before the edge.
    task automatic mid_step(input logic nr1, input logic nd1, input logic nr4, input logic [3:0] nd4);
        @(posedge clock);
        #2;
        r1 = nr1; d1 = nd1; r4 = nr4; d4 = nd4;
        #3;
        check("midcycle_q1", {3'b0, q1}, {3'b0, last1});
        check("midcycle_q4", q4, last4);
        push_expect();
    endtask

    // d pulses high and back low entirely between edges.
    task automatic glitch_step();
        @(posedge clock);
        #2;
        r1 = 1'b0; d1 = 1'b0; r4 = 1'b0; d4 = 4'b0000;
        #3;
        d1 = 1'b1; d4 = 4'b1111;
        #3;
        d1 = 1'b0; d4 = 4'b0000;
        push_expect();
    endtask

    // Monitor: each rising edge presents one output pair per instance.
    initial begin
        logic       e1;
        logic [3:0] e4;
        forever begin
            @(posedge clock);
            #1;
            if (exp1_q.size() > 0) begin
                e1 = exp1_q.pop_front();
                e4 = exp4_q.pop_front();
                check("q1", {3'b0, q1}, {3'b0, e1});
                check("q_bar1", {3'b0, qb1}, {3'b0, ~e1});
                check("q4", q4, e4);
                check("q_bar4", qb4, ~e4);
            end
        end
    end

    initial begin
        r1 = 1'b1; d1 = 1'b0; r4 = 1'b1; d4 = 4'b0000;

        // Reset held while d toggles.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'(i % 2), 1'b1, 4'($urandom));
        end

        // Normal capture with toggling d.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'((i + 1) % 2), 1'b0, 4'($urandom));
        end

        // Reset re-asserted with q=1 beforehand.
        step(1'b0, 1'b1, 1'b0, 4'b1111);
        mid_step(1'b1, 1'b1, 1'b1, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 4'($urandom));
        end
        // Reset released mid-cycle: q stays at the reset value until the edge.
        mid_step(1'b0, 1'b1, 1'b0, 4'b0110);

        // Mid-cycle glitch on d.
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        glitch_step();

        // d rising right after an edge is captured only on the following edge.
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b1001);

        // WIDTH=4 reset value for one edge, then capture.
        step(1'b1, 1'b1, 1'b1, 4'b1111);
        step(1'b0, 1'b0, 1'b0, 4'b0110);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 7) == 0), 1'($urandom),
                 ($urandom_range(0, 7) == 0), 4'($urandom));
        end

        repeat (2) @(posedge clock);
        #3;
        checks++;
        if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0",
                     exp1_q.size(), exp4_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
